// File: rtl/pool_pkg.sv
// Shared definitions for the pooling stage.
//   DATA_W       data/address word width
//   MAX_ELEMS    depth of the loaded block array
//   ACC_W        signed accumulator width
//   pool_state_t controller state encoding
//   log2_window  shift amount for a supported window side (1, 2, 4, 8)
package pool_pkg;

    localparam int DATA_W    = 16;
    localparam int MAX_ELEMS = 1024;
    localparam int ACC_W     = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACC,
        WRITE,
        NEXT,
        DONE
    } pool_state_t;

    // Unsupported sizes fall back to 0, so the core then behaves as a 1x1 window.
    function automatic logic [1:0] log2_window(input logic [DATA_W-1:0] window_size);
        logic [1:0] shift;
        case (window_size)
            16'd2:   shift = 2'd1;
            16'd4:   shift = 2'd2;
            16'd8:   shift = 2'd3;
            default: shift = 2'd0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/pool_window_unit.sv
// Reduces one pooling window, one element per cycle.
// Build option: POOL_MAX_POOL_EN selects max pooling; otherwise average pooling.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   clear        current element is the first of a new window (seeds the reduction)
//   valid        data carries a window element this cycle
//   data         signed element
//   shift        right-shift applied to the sum for averaging (log2 of element count)
//   result       reduction including the element presented this cycle, truncated
module pool_window_unit #(
    parameter int DATA_W = pool_pkg::DATA_W,
    parameter int ACC_W  = pool_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] data,
    input  logic        [2:0]        shift,
    output logic signed [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] acc_shifted;

    assign data_ext = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};

    always_comb begin
        acc_d = acc_q;
        if (valid) begin
            if (clear) begin
                acc_d = data_ext;
            end else begin
`ifdef POOL_MAX_POOL_EN
                acc_d = (data_ext > acc_q) ? data_ext : acc_q;
`else
                acc_d = acc_q + data_ext;
`endif
            end
        end
    end

    // The result is taken from acc_d so the controller can capture the finished
    // window on the same edge that consumes its last element.
`ifdef POOL_MAX_POOL_EN
    assign acc_shifted = acc_d + ACC_W'(shift & 3'd0);
`else
    assign acc_shifted = acc_d >>> shift;
`endif
    assign result = acc_shifted[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pool_layer_core.sv
// Pooling stage: loads each square feature map through the load_block handshake,
// reduces non-overlapping windowSize x windowSize windows and writes one result
// word per window to a contiguous region following the input maps.
// Build option: POOL_MAX_POOL_EN selects max pooling (default: average pooling).
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   enable                     start (in IDLE) / hold done (in DONE)
//   imgsNumber, imgSize,       run configuration, sampled at start
//   imgsAddress, windowSize
//   loadDone, loadOut          load completion and loaded map (row-major)
//   loadEnable, loadAddr,      load request
//   loadSize
//   writeEnable, writeAddr,    single-word result write
//   writeOut
//   done                       run complete, held until enable drops
module pool_layer_core #(
    parameter int DATA_W    = pool_pkg::DATA_W,
    parameter int MAX_ELEMS = pool_pkg::MAX_ELEMS,
    parameter int ACC_W     = pool_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic        [DATA_W-1:0] imgsNumber,
    input  logic        [DATA_W-1:0] imgSize,
    input  logic        [DATA_W-1:0] imgsAddress,
    input  logic        [DATA_W-1:0] windowSize,
    input  logic                     loadDone,
    input  logic signed [DATA_W-1:0] loadOut [MAX_ELEMS],
    output logic                     loadEnable,
    output logic        [DATA_W-1:0] loadAddr,
    output logic        [DATA_W-1:0] loadSize,
    output logic                     writeEnable,
    output logic        [DATA_W-1:0] writeAddr,
    output logic signed [DATA_W-1:0] writeOut,
    output logic                     done
);

    import pool_pkg::*;

    localparam int IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;

    pool_state_t state_q, state_d;

    logic        [DATA_W-1:0] num_q, num_d;
    logic        [DATA_W-1:0] size_q, size_d;
    logic        [DATA_W-1:0] elems_q, elems_d;
    logic        [DATA_W-1:0] o_q, o_d;
    logic        [1:0]        wshift_q, wshift_d;
    logic        [2:0]        win_m1_q, win_m1_d;
    logic        [DATA_W-1:0] k_q, k_d;
    logic        [DATA_W-1:0] i_q, i_d;
    logic        [DATA_W-1:0] j_q, j_d;
    logic        [2:0]        wr_q, wr_d;
    logic        [2:0]        wc_q, wc_d;
    logic        [DATA_W-1:0] wr_ptr_q, wr_ptr_d;

    logic                     load_enable_q, load_enable_d;
    logic        [DATA_W-1:0] load_addr_q, load_addr_d;
    logic        [DATA_W-1:0] load_size_q, load_size_d;
    logic                     write_enable_q, write_enable_d;
    logic        [DATA_W-1:0] write_addr_q, write_addr_d;
    logic signed [DATA_W-1:0] write_out_q, write_out_d;
    logic                     done_q, done_d;

    // Start-time derived values
    logic        [1:0]        start_shift;
    logic        [DATA_W-1:0] start_o;
    logic        [DATA_W-1:0] start_elems;
    logic        [DATA_W-1:0] start_base;
    logic        [DATA_W-1:0] k_next;

    // Element addressing inside the loaded block
    logic        [DATA_W-1:0] row;
    logic        [DATA_W-1:0] col;
    logic        [IDX_W-1:0]  elem_idx;
    logic signed [DATA_W-1:0] elem;

    logic                     win_clear;
    logic                     win_valid;
    logic        [2:0]        win_shift;
    logic signed [DATA_W-1:0] win_result;

    assign row      = (i_q << wshift_q) + DATA_W'(wr_q);
    assign col      = (j_q << wshift_q) + DATA_W'(wc_q);
    assign elem_idx = IDX_W'(row * size_q + col);
    assign elem     = loadOut[elem_idx];

    assign win_valid = (state_q == ACC);
    assign win_clear = (wr_q == 3'd0) && (wc_q == 3'd0);
    assign win_shift = {wshift_q, 1'b0};  // element count is 4^wshift

    pool_window_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .clear  (win_clear),
        .valid  (win_valid),
        .data   (elem),
        .shift  (win_shift),
        .result (win_result)
    );

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        size_d         = size_q;
        elems_d        = elems_q;
        o_d            = o_q;
        wshift_d       = wshift_q;
        win_m1_d       = win_m1_q;
        k_d            = k_q;
        i_d            = i_q;
        j_d            = j_q;
        wr_d           = wr_q;
        wc_d           = wc_q;
        wr_ptr_d       = wr_ptr_q;
        load_enable_d  = load_enable_q;
        load_addr_d    = load_addr_q;
        load_size_d    = load_size_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_out_d    = write_out_q;
        done_d         = done_q;

        start_shift = log2_window(windowSize);
        start_o     = imgSize >> start_shift;
        start_elems = imgSize * imgSize;
        start_base  = imgsAddress + imgsNumber * start_elems;
        k_next      = k_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    num_d    = imgsNumber;
                    size_d   = imgSize;
                    elems_d  = start_elems;
                    o_d      = start_o;
                    wshift_d = start_shift;
                    win_m1_d = 3'((4'd1 << start_shift) - 4'd1);
                    k_d      = '0;
                    i_d      = '0;
                    j_d      = '0;
                    wr_d     = '0;
                    wc_d     = '0;
                    wr_ptr_d = start_base;
                    if ((imgsNumber == '0) || (start_o == '0)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        load_enable_d = 1'b1;
                        load_addr_d   = imgsAddress;
                        load_size_d   = start_elems;
                        state_d       = LOAD;
                    end
                end
            end

            LOAD: begin
                if (loadDone) begin
                    load_enable_d = 1'b0;
                    state_d       = ACC;
                end
            end

            ACC: begin
                // Raster walk within the window; the last element hands the
                // finished result straight to the write registers.
                if (wc_q == win_m1_q) begin
                    wc_d = '0;
                    if (wr_q == win_m1_q) begin
                        wr_d           = '0;
                        write_enable_d = 1'b1;
                        write_addr_d   = wr_ptr_q;
                        write_out_d    = win_result;
                        state_d        = WRITE;
                    end else begin
                        wr_d = wr_q + 3'd1;
                    end
                end else begin
                    wc_d = wc_q + 3'd1;
                end
            end

            WRITE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (j_q == o_q - 1'b1) begin
                    j_d = '0;
                    if (i_q == o_q - 1'b1) begin
                        i_d     = '0;
                        state_d = NEXT;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ACC;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ACC;
                end
            end

            NEXT: begin
                k_d = k_next;
                if (k_next < num_q) begin
                    load_enable_d = 1'b1;
                    load_addr_d   = load_addr_q + elems_q;
                    load_size_d   = elems_q;
                    state_d       = LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (!enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            num_q          <= '0;
            size_q         <= '0;
            elems_q        <= '0;
            o_q            <= '0;
            wshift_q       <= '0;
            win_m1_q       <= '0;
            k_q            <= '0;
            i_q            <= '0;
            j_q            <= '0;
            wr_q           <= '0;
            wc_q           <= '0;
            wr_ptr_q       <= '0;
            load_enable_q  <= 1'b0;
            load_addr_q    <= '0;
            load_size_q    <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_out_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            size_q         <= size_d;
            elems_q        <= elems_d;
            o_q            <= o_d;
            wshift_q       <= wshift_d;
            win_m1_q       <= win_m1_d;
            k_q            <= k_d;
            i_q            <= i_d;
            j_q            <= j_d;
            wr_q           <= wr_d;
            wc_q           <= wc_d;
            wr_ptr_q       <= wr_ptr_d;
            load_enable_q  <= load_enable_d;
            load_addr_q    <= load_addr_d;
            load_size_q    <= load_size_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_out_q    <= write_out_d;
            done_q         <= done_d;
        end
    end

    assign loadEnable  = load_enable_q;
    assign loadAddr    = load_addr_q;
    assign loadSize    = load_size_q;
    assign writeEnable = write_enable_q;
    assign writeAddr   = write_addr_q;
    assign writeOut    = write_out_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pool_layer_core.sv
// Directed self-checking bench for pool_layer_core. A load_block model answers
// load requests from a small word memory; a monitor logs loads and writes.
module tb_pool_layer_core;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic        [15:0] imgsNumber, imgSize, imgsAddress, windowSize;
    logic               loadDone;
    logic signed [15:0] loadOut [1024];
    logic               loadEnable, writeEnable, done;
    logic        [15:0] loadAddr, loadSize, writeAddr;
    logic signed [15:0] writeOut;

    logic signed [15:0] mem [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] la_q[$];
    logic [15:0] ls_q[$];
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wcyc_q[$];
    int          overlap;
    int          done_cyc;
    int          lat;
    logic        le_prev;
    logic        done_prev;

    always #5 clk = ~clk;

    pool_layer_core dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .imgsNumber  (imgsNumber),
        .imgSize     (imgSize),
        .imgsAddress (imgsAddress),
        .windowSize  (windowSize),
        .loadDone    (loadDone),
        .loadOut     (loadOut),
        .loadEnable  (loadEnable),
        .loadAddr    (loadAddr),
        .loadSize    (loadSize),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .writeOut    (writeOut),
        .done        (done)
    );

    // Monitor and load_block responder, both working on the falling edge.
    initial begin
        lat       = 0;
        le_prev   = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (writeEnable) begin
                wa_q.push_back(writeAddr);
                wd_q.push_back(writeOut);
                wcyc_q.push_back(cyc);
            end
            if (loadEnable && writeEnable) overlap++;
            if (loadEnable && !le_prev) begin
                la_q.push_back(loadAddr);
                ls_q.push_back(loadSize);
            end
            if (done && !done_prev) done_cyc = cyc;
            le_prev   = loadEnable;
            done_prev = done;
            if (loadEnable) begin
                if (lat == 2) begin
                    for (int e = 0; e < 1024; e++) begin
                        if (e < int'(loadSize) && (int'(loadAddr) + e) < 256)
                            loadOut[e] = mem[int'(loadAddr) + e];
                    end
                    loadDone = 1'b1;
                end else begin
                    loadDone = 1'b0;
                end
                lat++;
            end else begin
                lat      = 0;
                loadDone = 1'b0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input int n, input int sz, input int a, input int w);
        tick();
        imgsNumber  = 16'(n);
        imgSize     = 16'(sz);
        imgsAddress = 16'(a);
        windowSize  = 16'(w);
        la_q.delete();
        ls_q.delete();
        wa_q.delete();
        wd_q.delete();
        wcyc_q.delete();
        overlap  = 0;
        done_cyc = -1;
        enable   = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: done=%0b required 1", tag, done);
        end
        tick();
    endtask

    task automatic stop_job;
        tick();
        enable = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_writes(input string tag, input int base, input logic signed [15:0] exp_d [16], input int n);
        total++;
        if (wa_q.size() != n) begin
            bad++;
            $display("FAIL %s_write_count: got %0d required %0d", tag, wa_q.size(), n);
        end
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== 16'(base + i)) begin
                bad++;
                $display("FAIL %s_waddr[%0d]: got %0d required %0d", tag, i, wa_q[i], base + i);
            end
            total++;
            if (wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL %s_wdata[%0d]: got %0d required %0d", tag, i, $signed(wd_q[i]), exp_d[i]);
            end
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL %s_overlap: got %0d cycles required 0", tag, overlap);
        end
    endtask

    task automatic check_loads(input string tag, input int first, input int step, input int sz, input int n);
        total++;
        if (la_q.size() != n) begin
            bad++;
            $display("FAIL %s_load_count: got %0d required %0d", tag, la_q.size(), n);
        end
        for (int i = 0; i < n && i < la_q.size(); i++) begin
            total++;
            if (la_q[i] !== 16'(first + i * step) || ls_q[i] !== 16'(sz)) begin
                bad++;
                $display("FAIL %s_load[%0d]: got addr=%0d size=%0d required addr=%0d size=%0d",
                         tag, i, la_q[i], ls_q[i], first + i * step, sz);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({loadEnable, writeEnable, done} !== 3'b000 || loadAddr !== 16'd0 || loadSize !== 16'd0
            || writeAddr !== 16'd0 || writeOut !== 16'sd0) begin
            bad++;
            $display("FAIL reset_outputs: got le=%0b we=%0b done=%0b la=%0d ls=%0d wa=%0d wo=%0d required all 0",
                     loadEnable, writeEnable, done, loadAddr, loadSize, writeAddr, writeOut);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic signed [15:0] exp_d [16];
        for (int a = 0; a < 256; a++) mem[a] = 16'(a);
`ifdef POOL_MAX_POOL_EN
        exp_d = '{5, 7, 13, 15, 21, 23, 29, 31, 37, 39, 45, 47, 0, 0, 0, 0};
`else
        exp_d = '{2, 4, 10, 12, 18, 20, 26, 28, 34, 36, 42, 44, 0, 0, 0, 0};
`endif
        start_job(3, 4, 0, 2);
        wait_done("basic");
        check_loads("basic", 0, 16, 16, 3);
        check_writes("basic", 48, exp_d, 12);
        total++;
        if (wcyc_q.size() >= 2 && (wcyc_q[1] - wcyc_q[0]) != 5) begin
            bad++;
            $display("FAIL basic_write_spacing: got %0d cycles required 5", wcyc_q[1] - wcyc_q[0]);
        end
        total++;
        if (wcyc_q.size() == 0 || done_cyc <= wcyc_q[wcyc_q.size()-1] || done !== 1'b1) begin
            bad++;
            $display("FAIL basic_done_after_write: got done=%0b done_cycle=%0d required done=1 after last write",
                     done, done_cyc);
        end
        stop_job();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_clear: got %0b required 0", done);
        end
    endtask

    task automatic test_negative;
        logic signed [15:0] exp_d [16];
        for (int a = 100; a < 104; a++) mem[a] = -16'sd3;
        mem[104] = -16'sd1;
        mem[105] = 16'sd0;
        mem[106] = 16'sd0;
        mem[107] = 16'sd0;
        exp_d = '{default: 16'sd0};
        exp_d[0] = -16'sd3;
`ifdef POOL_MAX_POOL_EN
        exp_d[1] = 16'sd0;
`else
        exp_d[1] = -16'sd1;
`endif
        start_job(2, 2, 100, 2);
        wait_done("neg");
        check_loads("neg", 100, 4, 4, 2);
        check_writes("neg", 108, exp_d, 2);
        stop_job();
    endtask

    task automatic test_partial_window;
        logic signed [15:0] exp_d [16];
        for (int a = 0; a < 25; a++) mem[a] = 16'(a);
        for (int r = 0; r < 5; r++) begin
            mem[r * 5 + 4] = 16'sd1000;
            mem[20 + r]    = 16'sd1000;
        end
        exp_d = '{default: 16'sd0};
`ifdef POOL_MAX_POOL_EN
        exp_d[0:3] = '{6, 8, 16, 18};
`else
        exp_d[0:3] = '{3, 5, 13, 15};
`endif
        start_job(1, 5, 0, 2);
        wait_done("trim");
        check_loads("trim", 0, 25, 25, 1);
        check_writes("trim", 25, exp_d, 4);
        stop_job();
    endtask

    task automatic test_zero_maps;
        start_job(0, 4, 0, 2);
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: got %0b required 1", done);
        end
        repeat (4) tick();
        total++;
        if (la_q.size() != 0 || wa_q.size() != 0) begin
            bad++;
            $display("FAIL zero_activity: got loads=%0d writes=%0d required 0 0", la_q.size(), wa_q.size());
        end
        stop_job();
    endtask

    task automatic test_midrun_reset;
        int n = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a);
        start_job(3, 4, 0, 2);
        while (wa_q.size() < 5 && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (wa_q.size() < 5) begin
            bad++;
            $display("FAIL rst_reach_map1: got %0d writes required 5", wa_q.size());
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({loadEnable, writeEnable, done} !== 3'b000 || loadAddr !== 16'd0 || loadSize !== 16'd0
            || writeAddr !== 16'd0 || writeOut !== 16'sd0) begin
            bad++;
            $display("FAIL rst_midrun_outputs: got le=%0b we=%0b done=%0b la=%0d ls=%0d wa=%0d wo=%0d required all 0",
                     loadEnable, writeEnable, done, loadAddr, loadSize, writeAddr, writeOut);
        end
        reset = 1'b1;
        tick();
        total++;
        if (loadEnable !== 1'b1 || loadAddr !== 16'd0 || loadSize !== 16'd16) begin
            bad++;
            $display("FAIL rst_restart_load: got le=%0b addr=%0d size=%0d required le=1 addr=0 size=16",
                     loadEnable, loadAddr, loadSize);
        end
        wait_done("rst_rerun");
        total++;
        if (wa_q.size() != 17) begin
            bad++;
            $display("FAIL rst_rerun_writes: got %0d required 17", wa_q.size());
        end
        stop_job();
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        imgsNumber  = '0;
        imgSize     = '0;
        imgsAddress = '0;
        windowSize  = '0;
        loadDone    = 1'b0;
        overlap     = 0;
        done_cyc    = -1;
        for (int e = 0; e < 1024; e++) loadOut[e] = '0;
        for (int a = 0; a < 256; a++) mem[a] = '0;

        test_reset();
        test_basic();
        test_negative();
        test_partial_window();
        test_zero_maps();
        test_midrun_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
